// File: rtl/mc_control_if.sv
// Control bundle between the multicycle controller and the MIPS datapath.
// The controller side (master) samples IR fields and ALU status and drives
// the mux selects, write strobes and exception/debug information.
interface mc_control_if #(
  parameter int CNT_W = 16
);
  // Requests and status coming from the datapath / system
  logic             SYS_load;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             ALU_zero;
  logic             ALU_overflow;

  // Datapath control driven by the controller
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             pc_load;
  logic             ir_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       ALU_control;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             REG_write_1;
  logic             DMEM_mem_read;
  logic             DMEM_mem_write;
  logic             epc_write;

  // Exception, progress and debug information
  logic [7:0]       exc_vector;
  logic [1:0]       cause;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  modport master (
    input  SYS_load, opcode, funct, ALU_zero, ALU_overflow,
    output pc_write, pc_src, pc_load, ir_write, alu_src_a, alu_src_b,
           ALU_control, reg_dst, mem_to_reg, REG_write_1, DMEM_mem_read,
           DMEM_mem_write, epc_write, exc_vector, cause, instr_done,
           instr_count, state
  );

  modport slave (
    output SYS_load, opcode, funct, ALU_zero, ALU_overflow,
    input  pc_write, pc_src, pc_load, ir_write, alu_src_a, alu_src_b,
           ALU_control, reg_dst, mem_to_reg, REG_write_1, DMEM_mem_read,
           DMEM_mem_write, epc_write, exc_vector, cause, instr_done,
           instr_count, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the MIPS datapath.
// Sequences fetch, decode, ALU, memory and writeback states, raises
// illegal-instruction and overflow exceptions, and counts retired
// instructions. State-only outputs are registered from the next state;
// the few outputs that depend on same-cycle inputs (SYS_load in FETCH,
// ALU_zero in BRANCH, funct in EXEC_R) are qualified by registered
// state flags so they still drop to 0 the moment reset is asserted.
module mc_control_fsm #(
  parameter logic [7:0] EXC_VECTOR = 8'hF0,
  parameter int         CNT_W      = 16
) (
  input  logic         SYS_clk,
  input  logic         SYS_reset,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    R_WB     = 4'd8,
    EXEC_I   = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    EXCEPT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;

  state_t           state_reg, state_next;
  logic [1:0]       cause_reg, cause_next;
  logic [CNT_W-1:0] instr_count_reg;

  // Registered state flags and Moore outputs
  logic       fetch_reg;
  logic       branch_reg;
  logic       exec_r_reg;
  logic       pc_write_reg;
  logic [1:0] pc_src_reg;
  logic       alu_src_a_reg;
  logic [1:0] alu_src_b_reg;
  logic [3:0] alu_control_reg;
  logic       reg_dst_reg;
  logic       mem_to_reg_reg;
  logic       reg_write_reg;
  logic       mem_read_reg;
  logic       mem_write_reg;
  logic       epc_write_reg;
  logic       instr_done_reg;

  // R-type function decode
  logic [3:0] alu_r_ctrl;
  logic       funct_legal;
  logic       funct_arith;

  // Translate funct into an ALU operation and flag ops that can overflow
  always_comb begin
    alu_r_ctrl  = ALU_ADD;
    funct_legal = 1'b1;
    funct_arith = 1'b0;
    case (bus.funct)
      FN_ADD:  begin alu_r_ctrl = ALU_ADD; funct_arith = 1'b1; end
      FN_SUB:  begin alu_r_ctrl = ALU_SUB; funct_arith = 1'b1; end
      FN_AND:  alu_r_ctrl = ALU_AND;
      FN_OR:   alu_r_ctrl = ALU_OR;
      FN_SLT:  alu_r_ctrl = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  // Next-state and exception-cause selection
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    case (state_reg)
      IDLE:   state_next = FETCH;
      // A pending PC load holds us in FETCH; no instruction is fetched
      FETCH:  if (!bus.SYS_load) state_next = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_R:         state_next = EXEC_R;
          OP_ADDI:      state_next = EXEC_I;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          default: begin
            state_next = EXCEPT;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      MEM_ADDR: state_next = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   state_next = MEM_WB;
      EXEC_R: begin
        if (!funct_legal) begin
          state_next = EXCEPT;
          cause_next = CAUSE_ILLEGAL;
        end else if (funct_arith && bus.ALU_overflow) begin
          state_next = EXCEPT;
          cause_next = CAUSE_OVERFLOW;
        end else begin
          state_next = R_WB;
        end
      end
      EXEC_I: begin
        if (bus.ALU_overflow) begin
          state_next = EXCEPT;
          cause_next = CAUSE_OVERFLOW;
        end else begin
          state_next = I_WB;
        end
      end
      MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP, EXCEPT: state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // State register, cause, retired counter and Moore outputs for the next state
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_reg       <= IDLE;
      cause_reg       <= CAUSE_NONE;
      instr_count_reg <= '0;
      fetch_reg       <= 1'b0;
      branch_reg      <= 1'b0;
      exec_r_reg      <= 1'b0;
      pc_write_reg    <= 1'b0;
      pc_src_reg      <= 2'b00;
      alu_src_a_reg   <= 1'b0;
      alu_src_b_reg   <= 2'b00;
      alu_control_reg <= ALU_ADD;
      reg_dst_reg     <= 1'b0;
      mem_to_reg_reg  <= 1'b0;
      reg_write_reg   <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      epc_write_reg   <= 1'b0;
      instr_done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      // The counter advances on the edge that leaves a retiring state
      if (instr_done_reg) instr_count_reg <= instr_count_reg + 1'b1;

      fetch_reg       <= 1'b0;
      branch_reg      <= 1'b0;
      exec_r_reg      <= 1'b0;
      pc_write_reg    <= 1'b0;
      pc_src_reg      <= 2'b00;
      alu_src_a_reg   <= 1'b0;
      alu_src_b_reg   <= 2'b00;
      alu_control_reg <= ALU_ADD;
      reg_dst_reg     <= 1'b0;
      mem_to_reg_reg  <= 1'b0;
      reg_write_reg   <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      epc_write_reg   <= 1'b0;
      instr_done_reg  <= 1'b0;

      case (state_next)
        FETCH: begin
          fetch_reg     <= 1'b1;
          alu_src_b_reg <= 2'b01;
        end
        DECODE: alu_src_b_reg <= 2'b11;
        MEM_ADDR: begin
          alu_src_a_reg <= 1'b1;
          alu_src_b_reg <= 2'b10;
        end
        MEM_RD: mem_read_reg <= 1'b1;
        MEM_WB: begin
          reg_write_reg  <= 1'b1;
          mem_to_reg_reg <= 1'b1;
          instr_done_reg <= 1'b1;
        end
        MEM_WR: begin
          mem_write_reg  <= 1'b1;
          instr_done_reg <= 1'b1;
        end
        EXEC_R: begin
          exec_r_reg    <= 1'b1;
          alu_src_a_reg <= 1'b1;
        end
        R_WB: begin
          reg_write_reg  <= 1'b1;
          reg_dst_reg    <= 1'b1;
          instr_done_reg <= 1'b1;
        end
        EXEC_I: begin
          alu_src_a_reg <= 1'b1;
          alu_src_b_reg <= 2'b10;
        end
        I_WB: begin
          reg_write_reg  <= 1'b1;
          instr_done_reg <= 1'b1;
        end
        BRANCH: begin
          branch_reg      <= 1'b1;
          alu_src_a_reg   <= 1'b1;
          alu_control_reg <= ALU_SUB;
          pc_src_reg      <= 2'b01;
          instr_done_reg  <= 1'b1;
        end
        JUMP: begin
          pc_src_reg     <= 2'b10;
          pc_write_reg   <= 1'b1;
          instr_done_reg <= 1'b1;
        end
        EXCEPT: begin
          epc_write_reg <= 1'b1;
          pc_src_reg    <= 2'b11;
          pc_write_reg  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Input-qualified strobes: fetch vs PC load, and the conditional branch write
  assign bus.pc_load  = fetch_reg & bus.SYS_load;
  assign bus.ir_write = fetch_reg & ~bus.SYS_load;
  assign bus.pc_write = (fetch_reg & ~bus.SYS_load) | pc_write_reg |
                        (branch_reg & bus.ALU_zero);
  assign bus.ALU_control = exec_r_reg ? alu_r_ctrl : alu_control_reg;

  assign bus.pc_src         = pc_src_reg;
  assign bus.alu_src_a      = alu_src_a_reg;
  assign bus.alu_src_b      = alu_src_b_reg;
  assign bus.reg_dst        = reg_dst_reg;
  assign bus.mem_to_reg     = mem_to_reg_reg;
  assign bus.REG_write_1    = reg_write_reg;
  assign bus.DMEM_mem_read  = mem_read_reg;
  assign bus.DMEM_mem_write = mem_write_reg;
  assign bus.epc_write      = epc_write_reg;
  assign bus.exc_vector     = EXC_VECTOR;
  assign bus.cause          = cause_reg;
  assign bus.instr_done     = instr_done_reg;
  assign bus.instr_count    = instr_count_reg;
  assign bus.state          = state_reg;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm: walks instructions through the
// controller state by state and compares states/strobes with hand values.
module tb_mc_control_fsm;

  logic SYS_clk;
  logic SYS_reset;
  int   checks;
  int   errors;

  mc_control_if #(.CNT_W(16)) bus ();

  mc_control_fsm #(.EXC_VECTOR(8'hF0), .CNT_W(16)) dut (
    .SYS_clk  (SYS_clk),
    .SYS_reset(SYS_reset),
    .bus      (bus)
  );

  // Strobe vector bits, MSB first
  localparam logic [9:0] PCW = 10'h200;  // pc_write
  localparam logic [9:0] PCL = 10'h100;  // pc_load
  localparam logic [9:0] IRW = 10'h080;  // ir_write
  localparam logic [9:0] RGW = 10'h040;  // REG_write_1
  localparam logic [9:0] MRD = 10'h020;  // DMEM_mem_read
  localparam logic [9:0] MWR = 10'h010;  // DMEM_mem_write
  localparam logic [9:0] EPC = 10'h008;  // epc_write
  localparam logic [9:0] DON = 10'h004;  // instr_done
  localparam logic [9:0] M2R = 10'h002;  // mem_to_reg
  localparam logic [9:0] RDS = 10'h001;  // reg_dst

  logic [9:0] strobes;
  assign strobes = {bus.pc_write, bus.pc_load, bus.ir_write, bus.REG_write_1,
                    bus.DMEM_mem_read, bus.DMEM_mem_write, bus.epc_write,
                    bus.instr_done, bus.mem_to_reg, bus.reg_dst};

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and check state plus the strobe vector
  task automatic step(input string tag, input logic [3:0] st, input logic [9:0] stb);
    @(posedge SYS_clk);
    #2;
    check_val({tag, ".state"}, 32'(bus.state), 32'(st));
    check_val({tag, ".strobes"}, 32'(strobes), 32'(stb));
    $display("step %s state=%0d strobes=%03h count=%0d cause=%0d",
             tag, bus.state, strobes, bus.instr_count, bus.cause);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    SYS_reset = 1'b1;
    bus.SYS_load = 1'b0;
    bus.opcode = 6'b000000;
    bus.funct = 6'b000000;
    bus.ALU_zero = 1'b0;
    bus.ALU_overflow = 1'b0;

    // Reset state
    step("reset", 4'd0, 10'h000);
    check_val("reset.count", 32'(bus.instr_count), 32'd0);
    check_val("reset.cause", 32'(bus.cause), 32'd0);
    check_val("reset.aluctl", 32'(bus.ALU_control), 32'b0010);
    check_val("reset.pcsrc", 32'(bus.pc_src), 32'd0);
    check_val("exc_vector", 32'(bus.exc_vector), 32'hF0);
    SYS_reset = 1'b0;
    #1;
    check_val("release.state", 32'(bus.state), 32'd0);

    // lw: 5 cycles
    bus.opcode = 6'b100011;
    step("lw.fetch", 4'd1, PCW | IRW);
    check_val("lw.fetch.srcb", 32'(bus.alu_src_b), 32'b01);
    check_val("lw.fetch.aluctl", 32'(bus.ALU_control), 32'b0010);
    step("lw.decode", 4'd2, 10'h000);
    check_val("lw.decode.srcb", 32'(bus.alu_src_b), 32'b11);
    step("lw.addr", 4'd3, 10'h000);
    check_val("lw.addr.srca", 32'(bus.alu_src_a), 32'd1);
    check_val("lw.addr.srcb", 32'(bus.alu_src_b), 32'b10);
    step("lw.rd", 4'd4, MRD);
    step("lw.wb", 4'd5, RGW | M2R | DON);
    check_val("lw.wb.count", 32'(bus.instr_count), 32'd0);

    // R add with overflow -> EXCEPT, cause 10
    bus.opcode = 6'b000000;
    bus.funct = 6'b100000;
    step("addov.fetch", 4'd1, PCW | IRW);
    check_val("lw.done.count", 32'(bus.instr_count), 32'd1);
    step("addov.decode", 4'd2, 10'h000);
    bus.ALU_overflow = 1'b1;
    step("addov.exec", 4'd7, 10'h000);
    check_val("addov.exec.aluctl", 32'(bus.ALU_control), 32'b0010);
    check_val("addov.exec.srca", 32'(bus.alu_src_a), 32'd1);
    check_val("addov.exec.srcb", 32'(bus.alu_src_b), 32'b00);
    step("addov.except", 4'd13, PCW | EPC);
    check_val("addov.pcsrc", 32'(bus.pc_src), 32'b11);
    check_val("addov.cause", 32'(bus.cause), 32'b10);
    bus.ALU_overflow = 1'b0;

    // Illegal opcode -> EXCEPT, cause 01, count unchanged
    bus.opcode = 6'b111111;
    step("ill.fetch", 4'd1, PCW | IRW);
    check_val("addov.count", 32'(bus.instr_count), 32'd1);
    step("ill.decode", 4'd2, 10'h000);
    step("ill.except", 4'd13, PCW | EPC);
    check_val("ill.cause", 32'(bus.cause), 32'b01);

    // beq not taken then taken
    bus.opcode = 6'b000100;
    step("beq0.fetch", 4'd1, PCW | IRW);
    check_val("ill.count", 32'(bus.instr_count), 32'd1);
    check_val("ill.cause.held", 32'(bus.cause), 32'b01);
    step("beq0.decode", 4'd2, 10'h000);
    step("beq0.branch", 4'd11, DON);
    check_val("beq0.pcsrc", 32'(bus.pc_src), 32'b01);
    check_val("beq0.aluctl", 32'(bus.ALU_control), 32'b0110);
    bus.ALU_zero = 1'b1;
    step("beq1.fetch", 4'd1, PCW | IRW);
    check_val("beq0.count", 32'(bus.instr_count), 32'd2);
    step("beq1.decode", 4'd2, 10'h000);
    step("beq1.branch", 4'd11, PCW | DON);
    check_val("beq1.pcsrc", 32'(bus.pc_src), 32'b01);
    bus.ALU_zero = 1'b0;

    // R sub with SYS_load raised during EXEC_R
    bus.opcode = 6'b000000;
    bus.funct = 6'b100010;
    step("sub.fetch", 4'd1, PCW | IRW);
    step("sub.decode", 4'd2, 10'h000);
    bus.SYS_load = 1'b1;
    step("sub.exec", 4'd7, 10'h000);
    check_val("sub.exec.aluctl", 32'(bus.ALU_control), 32'b0110);
    step("sub.wb", 4'd8, RGW | RDS | DON);
    step("load.fetch0", 4'd1, PCL);
    check_val("sub.count", 32'(bus.instr_count), 32'd4);
    step("load.fetch1", 4'd1, PCL);
    bus.SYS_load = 1'b0;
    bus.opcode = 6'b000010;
    #1;
    check_val("load.release.strobes", 32'(strobes), 32'(PCW | IRW));

    // j
    step("j.decode", 4'd2, 10'h000);
    step("j.jump", 4'd12, PCW | DON);
    check_val("j.pcsrc", 32'(bus.pc_src), 32'b10);

    // sw: 4 cycles
    bus.opcode = 6'b101011;
    step("sw.fetch", 4'd1, PCW | IRW);
    check_val("j.count", 32'(bus.instr_count), 32'd5);
    step("sw.decode", 4'd2, 10'h000);
    step("sw.addr", 4'd3, 10'h000);
    step("sw.wr", 4'd6, MWR | DON);

    // addi with overflow
    bus.opcode = 6'b001000;
    step("addi.fetch", 4'd1, PCW | IRW);
    check_val("sw.count", 32'(bus.instr_count), 32'd6);
    step("addi.decode", 4'd2, 10'h000);
    bus.ALU_overflow = 1'b1;
    step("addi.exec", 4'd9, 10'h000);
    check_val("addi.exec.srcb", 32'(bus.alu_src_b), 32'b10);
    step("addi.except", 4'd13, PCW | EPC);
    check_val("addi.cause", 32'(bus.cause), 32'b10);
    bus.ALU_overflow = 1'b0;

    // R with illegal funct
    bus.opcode = 6'b000000;
    bus.funct = 6'b000001;
    step("badfn.fetch", 4'd1, PCW | IRW);
    step("badfn.decode", 4'd2, 10'h000);
    step("badfn.exec", 4'd7, 10'h000);
    step("badfn.except", 4'd13, PCW | EPC);
    check_val("badfn.cause", 32'(bus.cause), 32'b01);

    // Reset asserted mid MEM_RD
    bus.opcode = 6'b100011;
    step("rst.fetch", 4'd1, PCW | IRW);
    check_val("badfn.count", 32'(bus.instr_count), 32'd6);
    step("rst.decode", 4'd2, 10'h000);
    step("rst.addr", 4'd3, 10'h000);
    step("rst.rd", 4'd4, MRD);
    SYS_reset = 1'b1;
    #1;
    check_val("rst.async.state", 32'(bus.state), 32'd0);
    check_val("rst.async.strobes", 32'(strobes), 32'd0);
    check_val("rst.async.count", 32'(bus.instr_count), 32'd0);
    step("rst.held", 4'd0, 10'h000);
    SYS_reset = 1'b0;
    step("rst.idle_to_fetch", 4'd1, PCW | IRW);
    step("rst.decode2", 4'd2, 10'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
